// File: rtl/bcd_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
package bcd_pkg;

   typedef enum logic {IDLE, SHIFT} state_t;

   localparam int BCD_DIGIT_W = 4;

   function automatic int cnt_w(input int width);
      return (width > 1) ? $clog2(width) : 1;
   endfunction

endpackage

// File: rtl/bin_to_bcd_seq_if.sv
// Request/result bundle between a register source and the BCD converter.
interface bin_to_bcd_seq_if #(
   parameter int WIDTH  = 16,
   parameter int DIGITS = 5
);
   import bcd_pkg::*;

   logic                          start;
   logic [WIDTH-1:0]              bin;
   logic                          busy;
   logic                          done;
   logic [BCD_DIGIT_W*DIGITS-1:0] bcd;

   modport master (
      output start, bin,
      input  busy, done, bcd
   );

   modport slave (
      input  start, bin,
      output busy, done, bcd
   );

endinterface

// File: rtl/bcd_add3_cell.sv
// Double-dabble digit correction: add 3 when the digit is 5 or more.
module bcd_add3_cell
   import bcd_pkg::*;
(
   input  logic [BCD_DIGIT_W-1:0] din,
   output logic [BCD_DIGIT_W-1:0] dout
);

   assign dout = (din >= 4'd5) ? din + 4'd3 : din;

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Shift-add-3 binary to BCD converter, one input bit per clock.
module bin_to_bcd_seq
   import bcd_pkg::*;
#(
   parameter int WIDTH  = 16,
   parameter int DIGITS = 5
) (
   input logic             clock,
   input logic             resetn,
   bin_to_bcd_seq_if.slave bus
);

   localparam int SW = BCD_DIGIT_W * DIGITS;
   localparam int CW = cnt_w(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   state_t              state;
   logic [CW-1:0]       cnt;
   logic [WIDTH-1:0]    sh;
   logic [SW-1:0]       scr;
   logic [SW-1:0]       corr;
   logic [SW+WIDTH-1:0] cat;

   for (genvar g = 0; g < DIGITS; g++) begin : g_cell
      bcd_add3_cell u_cell (
         .din  (scr[g*BCD_DIGIT_W +: BCD_DIGIT_W]),
         .dout (corr[g*BCD_DIGIT_W +: BCD_DIGIT_W])
      );
   end

   // corrected digits and the binary operand shift as one word
   assign cat = {corr, sh} << 1;

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state    <= IDLE;
         cnt      <= '0;
         sh       <= '0;
         scr      <= '0;
         bus.busy <= 1'b0;
         bus.done <= 1'b0;
         bus.bcd  <= '0;
      end else begin
         bus.done <= 1'b0;
         unique case (state)
            IDLE: begin
               if (bus.start) begin
                  state    <= SHIFT;
                  sh       <= bus.bin;
                  scr      <= '0;
                  cnt      <= '0;
                  bus.busy <= 1'b1;
               end
            end
            SHIFT: begin
               scr <= cat[SW+WIDTH-1:WIDTH];
               sh  <= cat[WIDTH-1:0];
               cnt <= cnt + 1'b1;
               if (cnt == LAST) begin
                  state    <= IDLE;
                  bus.busy <= 1'b0;
                  bus.done <= 1'b1;
                  bus.bcd  <= cat[SW+WIDTH-1:WIDTH];
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Self-checking bench: decimal reference model plus directed and random runs.
module tb_bin_to_bcd_seq;

   localparam int W  = 16;
   localparam int D  = 5;
   localparam int BW = 4 * D;

   logic clock;
   logic resetn;

   bin_to_bcd_seq_if #(.WIDTH(W), .DIGITS(D)) bus ();

   bin_to_bcd_seq #(.WIDTH(W), .DIGITS(D)) dut (
      .clock  (clock),
      .resetn (resetn),
      .bus    (bus)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   int checks = 0;
   int errors = 0;
   int done_cnt = 0;

   function automatic logic [BW-1:0] to_bcd(input int v);
      logic [BW-1:0] r;
      int x;
      r = '0;
      x = v;
      for (int i = 0; i < D; i++) begin
         r[4*i +: 4] = 4'(x % 10);
         x = x / 10;
      end
      return r;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s act=%h exp=%h t=%0t", nm, act, exp, $time);
      end
   endtask

   // reference: value accepted when idle, result WIDTH edges later
   logic          m_busy = 1'b0;
   logic          m_done = 1'b0;
   logic [BW-1:0] m_bcd  = '0;
   logic [W-1:0]  m_val  = '0;
   int            m_left = 0;

   always @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         m_busy <= 1'b0;
         m_done <= 1'b0;
         m_bcd  <= '0;
         m_val  <= '0;
         m_left <= 0;
      end else begin
         m_done <= 1'b0;
         if (!m_busy) begin
            if (bus.start) begin
               m_busy <= 1'b1;
               m_left <= W;
               m_val  <= bus.bin;
            end
         end else begin
            if (m_left == 1) begin
               m_busy <= 1'b0;
               m_done <= 1'b1;
               m_bcd  <= to_bcd(int'(m_val));
            end
            m_left <= m_left - 1;
         end
      end
   end

   always @(negedge clock) begin
      if (resetn) begin
         chk("busy", 32'(bus.busy), 32'(m_busy));
         chk("done", 32'(bus.done), 32'(m_done));
         chk("bcd", 32'(bus.bcd), 32'(m_bcd));
         if (bus.done) done_cnt++;
      end
   end

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) @(negedge clock);
   endtask

   // leaves the bench at the negedge where done is high
   task automatic convert(input logic [W-1:0] v, input logic [BW-1:0] exp,
                          input string nm);
      int k;
      bus.start = 1'b1;
      bus.bin   = v;
      @(negedge clock);
      bus.start = 1'b0;
      k = 0;
      while (!bus.done && k < W + 6) begin
         @(negedge clock);
         k++;
      end
      chk({nm, "_latency"}, 32'(k), 32'(W));
      chk({nm, "_bcd"}, 32'(bus.bcd), 32'(exp));
   endtask

   initial begin
      int d0;
      resetn    = 1'b0;
      bus.start = 1'b0;
      bus.bin   = '0;

      chk("pin_1234", 32'(to_bcd(1234)), 32'h01234);
      chk("pin_65535", 32'(to_bcd(65535)), 32'h65535);
      chk("pin_100", 32'(to_bcd(100)), 32'h00100);

      idle(3);
      resetn = 1'b1;
      chk("rst_busy", 32'(bus.busy), 32'h0);
      chk("rst_done", 32'(bus.done), 32'h0);
      chk("rst_bcd", 32'(bus.bcd), 32'h0);
      idle(5);

      convert(16'd1234, 20'h01234, "c1234");
      @(negedge clock);
      chk("after_busy", 32'(bus.busy), 32'h0);
      chk("after_done", 32'(bus.done), 32'h0);
      idle(2);

      convert(16'd65535, 20'h65535, "c65535");
      idle(2);
      convert(16'd0, 20'h00000, "c0");
      idle(2);

      d0 = done_cnt;
      bus.start = 1'b1;
      bus.bin   = 16'd42;
      @(negedge clock);
      bus.start = 1'b0;
      idle(4);
      bus.start = 1'b1;
      bus.bin   = 16'd999;
      @(negedge clock);
      bus.start = 1'b0;
      idle(W + 8);
      chk("ign_bcd", 32'(bus.bcd), 32'h00042);
      chk("ign_ndone", 32'(done_cnt - d0), 32'd1);

      convert(16'd100, 20'h00100, "b2b_a");
      convert(16'd7, 20'h00007, "b2b_b");
      idle(2);

      d0 = done_cnt;
      bus.start = 1'b1;
      bus.bin   = 16'd9999;
      @(negedge clock);
      bus.start = 1'b0;
      idle(7);
      resetn = 1'b0;
      #1;
      chk("mid_busy", 32'(bus.busy), 32'h0);
      chk("mid_done", 32'(bus.done), 32'h0);
      chk("mid_bcd", 32'(bus.bcd), 32'h0);
      @(negedge clock);
      resetn = 1'b1;
      idle(W + 6);
      chk("mid_ndone", 32'(done_cnt - d0), 32'd0);
      convert(16'd5, 20'h00005, "c5");
      idle(2);

      for (int i = 0; i < 800; i++) begin
         bus.start = ($urandom_range(0, 3) == 0);
         bus.bin   = W'($urandom);
         @(negedge clock);
      end
      bus.start = 1'b0;
      idle(W + 4);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog act=timeout exp=finish");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/bin_to_bcd_seq.md
Name: bin_to_bcd_seq

Overview:
- Sequential binary-to-BCD converter using shift-add-3 (double dabble), one bit per clock.
- Sits between processor register outputs (R0..R7, 16-bit) and the 7-segment digit decoders.
- Replaces combinational %10 and /10 logic with one multi-cycle unit per displayed register.
- Delivers all decimal digits of a value together, held stable until the next conversion completes.

Parameters:
- WIDTH, 16, binary input width.
- DIGITS, 5, number of BCD output digits; must satisfy 10^DIGITS > 2^WIDTH-1 (5 digits covers 65535).

Ports:
- clock  input  1  system clock, rising edge.
- resetn  input  1  reset, asynchronous, active-low.
- start  input  1  request conversion of bin; sampled on rising edge of clock.
- bin  input  WIDTH  binary value; captured only on the edge that accepts start.
- busy  output  1  high while a conversion is in progress.
- done  output  1  single-cycle pulse; bcd has just been updated.
- bcd  output  4*DIGITS  packed digits, [3:0] = units, [7:4] = tens, and so on up to the most significant digit.

Behaviour:
- One clock; reset is asynchronous and active-low (clock, resetn).
- Reset values: busy=0, done=0, bcd=0, state=IDLE, shift counter=0, scratch registers=0.
- States:
  - IDLE: if start=1 at an edge, latch bin into the shift register, clear the BCD scratch, set count=0, go to SHIFT. Otherwise stay.
  - SHIFT: each edge, first correct each scratch digit (add 3 if digit >= 5, per digit, all digits in parallel), then shift {scratch, shift register} left by 1, then count++.
  - Exit from SHIFT: on the edge where count = WIDTH-1, the corrected and shifted result goes directly into bcd; done<=1; state goes to IDLE.
- Timing:
  - start accepted at edge E0; busy=1 from E0 to E(WIDTH).
  - At edge E(WIDTH) (E16 by default): bcd updated, done=1 for exactly one cycle, busy=0.
  - Latency from start to done is WIDTH cycles.
- done is registered and held high for one cycle only; it is cleared on the next edge unconditionally.
- A start while busy=1 is ignored. No queuing, and bin is not re-sampled.
- A start in the cycle where done=1 (state IDLE) is accepted. This gives back-to-back conversions, one result every WIDTH cycles.
- bcd holds its last result through an entire conversion; intermediate scratch values never appear on bcd.
- Each digit of bcd is always 0..9.
- Reset mid-conversion: everything returns to reset values immediately (asynchronous); bcd=0 and no done pulse.
- Width rules:
  - Scratch register is 4*DIGITS bits; the add-3 result is 4 bits per digit with no carry between digits before the shift.
  - The shift register is WIDTH bits; its MSB shifts into bit 0 of the scratch.
- bin=0 produces bcd=0 with full latency; there is no early termination.

Decomposition:
- Shared package bcd_pkg:
  - state enum {IDLE, SHIFT}.
  - Constant BCD_DIGIT_W=4.
  - Function or constant for the counter width, clog2(WIDTH).
- Sub-module bcd_add3_cell: 4-bit in, 4-bit out, out = (in >= 5) ? in+3 : in. Instantiated DIGITS times with a generate loop.
- Top of the block holds only the FSM, counter, shift/scratch registers and the output register.

Test Plan:
- Reset, then idle 5 cycles with start=0 -> busy=0, done=0, bcd=0 throughout.
- start pulse with bin=1234 -> busy=1 for 16 cycles, then done=1 for one cycle, bcd=0x01234. After that, busy=0 and done=0.
- bin=65535 -> bcd=0x65535. Also bin=0 -> bcd=0x00000, with done still arriving 16 cycles after start.
- Start with bin=42; pulse start with bin=999 at cycle 5 while busy -> only bin=42 completes, bcd=0x00042, and no second done follows.
- Start bin=100, then assert start with bin=7 in the cycle done is high -> first bcd=0x00100; second done 16 cycles later with bcd=0x00007. Between the two done pulses, bcd stays 0x00100.
- Start bin=9999; drop resetn at cycle 8 for one cycle, then release -> busy=0 and bcd=0 immediately, and no done pulse. A new start with bin=5 then yields bcd=0x00005 after 16 cycles.
